// File: rtl/bcd_seg_encoder.sv
// bcd_seg_encoder: converts a 14-bit binary value into four 7-segment digits
// using an iterative shift-add-3 engine. The output word is registered and held
// between updates, so the serial digit driver can sample it at any time.
//
// state   | meaning
// --------+--------------------------------------------------------------
// IDLE    | waiting for start; seg_data holds the last result
// CONVERT | one shift-add-3 iteration per clock, 14 iterations in total
// ENCODE  | register seg_data from the BCD nibbles and pulse done
module bcd_seg_encoder #(
  parameter bit BLANK_LZ       = 1'b1,
  parameter bit SEG_ACTIVE_LOW = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [13:0] value,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic [31:0] seg_data
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CONVERT = 2'd1,
    ENCODE  = 2'd2
  } state_t;

  localparam logic [31:0] BLANK_WORD = {32{SEG_ACTIVE_LOW}};
  localparam logic [7:0]  SEG_DASH   = 8'h40;
  localparam logic [3:0]  LAST_ITER  = 4'd13;

  state_t      state, state_nxt;
  logic [29:0] sreg;   // [29:14] BCD digits, [13:0] binary still to shift in
  logic [29:0] adj;
  logic [3:0]  iter;
  logic        ovf;
  logic [31:0] seg_word;

  function automatic logic [7:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 8'h3F;
      4'd1:    seg7 = 8'h06;
      4'd2:    seg7 = 8'h5B;
      4'd3:    seg7 = 8'h4F;
      4'd4:    seg7 = 8'h66;
      4'd5:    seg7 = 8'h6D;
      4'd6:    seg7 = 8'h7D;
      4'd7:    seg7 = 8'h07;
      4'd8:    seg7 = 8'h7F;
      4'd9:    seg7 = 8'h6F;
      default: seg7 = 8'h00;
    endcase
  endfunction

  assign busy = (state != IDLE);

  // Add 3 to every BCD nibble that is 5 or more, ahead of the left shift.
  // The top nibble may wrap for values above 9999; ovf masks that result.
  always_comb begin
    adj = sreg;
    for (int i = 0; i < 4; i++) begin
      if (sreg[14+4*i +: 4] >= 4'd5)
        adj[14+4*i +: 4] = sreg[14+4*i +: 4] + 4'd3;
    end
  end

  // Build the display word from the finished BCD digits.
  always_comb begin
    logic [3:0] d3, d2, d1, d0;
    logic [7:0] b3, b2, b1;
    d3 = sreg[29:26];
    d2 = sreg[25:22];
    d1 = sreg[21:18];
    d0 = sreg[17:14];
    b3 = seg7(d3);
    b2 = seg7(d2);
    b1 = seg7(d1);
    if (BLANK_LZ) begin
      if (d3 == 4'd0)                               b3 = 8'h00;
      if (d3 == 4'd0 && d2 == 4'd0)                 b2 = 8'h00;
      if (d3 == 4'd0 && d2 == 4'd0 && d1 == 4'd0)   b1 = 8'h00;
    end
    seg_word = {b3, b2, b1, seg7(d0)};
    if (ovf)
      seg_word = {4{SEG_DASH}};
    if (SEG_ACTIVE_LOW)
      seg_word = ~seg_word;
  end

  // Next-state selection.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = CONVERT;
      CONVERT: if (iter == LAST_ITER) state_nxt = ENCODE;
      ENCODE:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Conversion datapath, output word and done pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      sreg     <= '0;
      iter     <= '0;
      ovf      <= 1'b0;
      done     <= 1'b0;
      seg_data <= BLANK_WORD;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            sreg <= {16'b0, value};
            iter <= '0;
            ovf  <= (value > 14'd9999);
          end
        end
        CONVERT: begin
          sreg <= adj << 1;
          iter <= iter + 4'd1;
        end
        ENCODE: begin
          seg_data <= seg_word;
          done     <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
